// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder side of the CPU data-SRAM interface. Serves
//                loads/stores from a word-addressed RAM plus a small MMIO
//                window (LED, switches, free-running timer, scratch) with
//                a fixed one-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // MMIO register word offsets (addr[15:2])
  localparam logic [13:0] OFF_LED     = 14'h0000;
  localparam logic [13:0] OFF_SWITCH  = 14'h0001;
  localparam logic [13:0] OFF_TIMER   = 14'h0002;
  localparam logic [13:0] OFF_SCRATCH = 14'h0003;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;

  logic                  is_mmio;
  logic                  rd_req;
  logic                  wr_req;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [13:0]           mmio_off;
  logic [31:0]           byte_mask;
  logic                  unused_addr_bits;

  // Byte offset inside a word carries no meaning for a word-wide port.
  assign unused_addr_bits = ^sram_addr[1:0];

  // Request classification and address decode
  always_comb begin
    is_mmio   = (sram_addr[31:16] == MMIO_BASE[31:16]);
    ram_idx   = sram_addr[DEPTH_LOG2+1:2];
    mmio_off  = sram_addr[15:2];
    rd_req    = sram_en && (sram_we == 4'b0000);
    wr_req    = sram_en && (sram_we != 4'b0000);
    byte_mask = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};
  end

  // Next-state for read data and MMIO registers; timer free-runs unless written
  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;

    // Decode is only evaluated under a valid request so idle-cycle garbage
    // on address/data never reaches state.
    if (rd_req) begin
      if (is_mmio) begin
        case (mmio_off)
          OFF_LED:     rdata_d = {16'h0000, led_q};
          OFF_SWITCH:  rdata_d = {24'h000000, switch};
          OFF_TIMER:   rdata_d = timer_q;
          OFF_SCRATCH: rdata_d = scratch_q;
          default:     rdata_d = 32'h0000_0000;
        endcase
      end else begin
        rdata_d = mem[ram_idx];
      end
    end

    if (wr_req) begin
      if (is_mmio) begin
        case (mmio_off)
          OFF_LED:     led_d     = (led_q & ~byte_mask[15:0]) | (sram_wdata[15:0] & byte_mask[15:0]);
          OFF_TIMER:   timer_d   = (timer_q & ~byte_mask) | (sram_wdata & byte_mask);
          OFF_SCRATCH: scratch_d = (scratch_q & ~byte_mask) | (sram_wdata & byte_mask);
          default:     ;
        endcase
      end
    end
  end

  // Register bank with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q   <= 32'h0000_0000;
      led_q     <= 16'h0000;
      timer_q   <= 32'h0000_0000;
      scratch_q <= 32'h0000_0000;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
    end
  end

  // RAM byte-lane writes; contents survive reset but reset-cycle stores drop
  always_ff @(posedge clk) begin
    if (resetn && wr_req && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign sram_rdata = rdata_q;
  assign led        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Directed scenarios
//                followed by random traffic, compared against a
//                transaction-level model of the memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_rdata;
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_scratch;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .MMIO_BASE(MMIO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .switch     (switch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = we[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    return (old & ~lane_mask(we)) | (nw & lane_mask(we));
  endfunction

  // One bus transaction as seen at a single rising edge
  task automatic model_edge(input logic rn, input logic en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] sw);
    logic        mmio;
    logic [15:0] off;
    int          key;
    logic        timer_written;
    logic [31:0] old;
    if (!rn) begin
      m_rdata = 0; m_led = 0; m_timer = 0; m_scratch = 0;
      return;
    end
    mmio = (addr[31:16] == MMIO[31:16]);
    off  = addr[15:0] & 16'hFFFC;
    key  = int'((addr >> 2) % 1024);
    timer_written = 1'b0;
    if (en && we == 4'b0000) begin
      if (mmio) begin
        case (off)
          16'h0000: m_rdata = {16'h0, m_led};
          16'h0004: m_rdata = {24'h0, sw};
          16'h0008: m_rdata = m_timer;
          16'h000C: m_rdata = m_scratch;
          default:  m_rdata = 0;
        endcase
      end else begin
        m_rdata = m_ram.exists(key) ? m_ram[key] : 32'hxxxx_xxxx;
      end
    end
    if (en && we != 4'b0000) begin
      if (mmio) begin
        case (off)
          16'h0000: begin old = {16'h0, m_led}; old = merge(old, wd, we); m_led = old[15:0]; end
          16'h0008: begin m_timer = merge(m_timer, wd, we); timer_written = 1'b1; end
          16'h000C: m_scratch = merge(m_scratch, wd, we);
          default: ;
        endcase
      end else begin
        old = m_ram.exists(key) ? m_ram[key] : 32'h0;
        m_ram[key] = merge(old, wd, we);
      end
    end
    if (!timer_written) m_timer = m_timer + 1;
  endtask

  // Drive one cycle, advance the model, then compare the visible outputs
  task automatic step(input logic rn, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wd);
    resetn = rn; sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd;
    @(posedge clk);
    model_edge(rn, en, we, addr, wd, switch);
    #1;
    check("rdata_model", sram_rdata, m_rdata);
    check("led_model", {16'h0, led}, {16'h0, m_led});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 4'b0000, a, $urandom);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    step(1'b1, 1'b1, we, a, d);
  endtask

  initial begin
    logic [31:0] a, hi, keep;
    logic [3:0]  we;
    int          kind;

    switch = 8'h00;
    // Reset with garbage on the bus, including a store that must be dropped
    step(1'b0, 1'b1, 4'hF, MMIO + 32'h0, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);

    // Timer counts from zero once out of reset
    idle();
    rd(MMIO + 32'h8);
    check("timer_first", sram_rdata, 32'h1);
    rd(MMIO + 32'h8);
    check("timer_second", sram_rdata, 32'h2);

    // Full-word store then load
    wr(32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
    rd(32'h0000_1000);
    check("ram_full_word", sram_rdata, 32'hDEAD_BEEF);

    // Single-lane store leaves read data untouched during the store
    wr(32'h0000_1000, 4'b0100, 32'h00AA_0000);
    check("rdata_hold_on_write", sram_rdata, 32'hDEAD_BEEF);
    rd(32'h0000_1000);
    check("ram_byte_lane", sram_rdata, 32'hDEAA_BEEF);

    // LED, switch and unmapped MMIO offsets
    wr(MMIO + 32'h0, 4'hF, 32'hFFFF_1234);
    check("led_write", {16'h0, led}, 32'h0000_1234);
    rd(MMIO + 32'h0);
    check("led_readback", sram_rdata, 32'h0000_1234);
    switch = 8'h5A;
    rd(MMIO + 32'h4);
    check("switch_read", sram_rdata, 32'h0000_005A);
    wr(MMIO + 32'h4, 4'hF, 32'h1111_1111);
    rd(MMIO + 32'h20);
    check("unmapped_read", sram_rdata, 32'h0);

    // Timer load has priority over increment, then wraps
    wr(MMIO + 32'h8, 4'hF, 32'hFFFF_FFFE);
    idle();
    rd(MMIO + 32'h8);
    check("timer_max", sram_rdata, 32'hFFFF_FFFF);
    rd(MMIO + 32'h8);
    check("timer_wrap", sram_rdata, 32'h0);

    // RAM index aliasing above the implemented depth
    wr(32'h0000_0004, 4'hF, 32'hCAFE_F00D);
    rd(32'h0000_1004);
    check("ram_alias", sram_rdata, 32'hCAFE_F00D);

    // Scratch write lost when it coincides with reset
    wr(MMIO + 32'hC, 4'hF, 32'h5555_AAAA);
    rd(MMIO + 32'hC);
    check("scratch_set", sram_rdata, 32'h5555_AAAA);
    step(1'b0, 1'b1, 4'hF, MMIO + 32'hC, 32'h1234_5678);
    rd(MMIO + 32'hC);
    check("scratch_after_reset", sram_rdata, 32'h0);

    // Seed a small RAM window so random loads always hit known data
    for (int i = 0; i < 16; i++) wr(32'(i) << 2, 4'hF, $urandom);

    // Random traffic over RAM aliases and the MMIO window
    for (int n = 0; n < 400; n++) begin
      switch = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        hi = $urandom & 32'hFFFF_F000;
        if (hi[31:16] == MMIO[31:16]) hi = 32'h0;
        a = hi | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end else begin
        a = MMIO | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      end
      we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if (kind == 9) begin
        keep = sram_rdata;
        idle();
        check("idle_hold", sram_rdata, keep);
      end else begin
        step(1'b1, 1'b1, we, a, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
